// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared constants and the fetch entry type for the fetch unit
package riscv_fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries with flush and occupancy count
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LEVEL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       wdata,
    output fetch_entry_t       rdata,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LEVEL_W-1:0] count_q, count_d;

    assign rdata = mem_q[rd_q];
    assign full  = count_q == LEVEL_W'(DEPTH);
    assign empty = count_q == '0;
    assign level = count_q;

    // pointers wrap naturally; the count alone decides full/empty
    always_comb begin
        wr_d    = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
        count_d = count_q + LEVEL_W'(push) - LEVEL_W'(pop);
    end

    // pointer/count state, cleared by reset or flush
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // storage needs no reset: empty entries are never presented
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner, imem fetch, prefetch FIFO and redirect handling
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    parameter int          LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               misalign_err
);
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q, misalign_d;
    logic         push, pop, full, empty;
    fetch_entry_t head, wr_entry;

    assign imem_addr    = pc_q;
    assign out_valid    = !empty && !redirect_valid;
    assign pop          = out_valid && out_ready;
    assign push         = !redirect_valid && (!full || pop);
    assign wr_entry     = '{pc: pc_q, instr: imem_rdata};
    assign out_pc       = empty ? '0 : head.pc;
    assign out_instr    = empty ? '0 : head.instr;
    assign misalign_err = misalign_q;

    // redirect wins over sequential advance; pc only moves when a word is stored
    always_comb begin
        pc_d       = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'(INSTR_BYTES) : pc_q;
        misalign_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    end

    // pc and misalign flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .LEVEL_W(LEVEL_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed table plus randomized run against a queue model
module tb_instruction_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] RPC = 32'h0;

    logic        clk, reset, redirect_valid, out_ready, out_valid, misalign_err;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
    logic [1:0]  fifo_level;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mmis;

    typedef struct {
        bit rst; bit rv; logic [31:0] rpc; bit rdy; bit chk;
        bit v; logic [31:0] pc; logic [31:0] instr; int lvl; logic [31:0] addr; bit mis;
    } vec_t;
    vec_t tv[31];

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hFFC4A303;
            32'h4:   return 32'h0064A423;
            32'h8:   return 32'h0062E233;
            32'hC:   return 32'hFE420AE3;
            default: return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign imem_rdata = mem(imem_addr);

    instruction_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fifo_level(fifo_level), .misalign_err(misalign_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit rst, bit rv, logic [31:0] rpc, bit rdy, bit chk, bit v,
                                logic [31:0] pc, logic [31:0] instr, int lvl, logic [31:0] addr, bit mis);
        vec_t t;
        t = '{rst, rv, rpc, rdy, chk, v, pc, instr, lvl, addr, mis};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_all(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                             input int lvl, input logic [31:0] addr, input bit mis);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_pc", out_pc, pc);
        chk("out_instr", out_instr, instr);
        chk("fifo_level", 32'(fifo_level), 32'(lvl));
        chk("imem_addr", imem_addr, addr);
        chk("misalign_err", 32'(misalign_err), 32'(mis));
    endtask

    task automatic model_edge();
        if (reset) begin
            mq.delete(); mpc = RPC; mmis = 0;
        end else if (redirect_valid) begin
            mq.delete(); mpc = {redirect_pc[31:2], 2'b00}; mmis = redirect_pc[1:0] != 0;
        end else begin
            mmis = 0;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                mq.push_back('{mpc, mem(mpc)});
                mpc += 4;
            end
        end
    endtask

    task automatic drive(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        reset = rst; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        #1;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        cyc++;
    endtask

    initial begin
        reset = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 0; mpc = RPC; mmis = 0;
        tv[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0, 0);
        tv[2]  = mk(0, 0, 0, 1, 1, 1, 32'h0, 32'hFFC4A303, 1, 32'h4, 0);
        tv[3]  = mk(0, 0, 0, 1, 1, 1, 32'h4, 32'h0064A423, 1, 32'h8, 0);
        tv[4]  = mk(0, 0, 0, 1, 1, 1, 32'h8, 32'h0062E233, 1, 32'hC, 0);
        tv[5]  = mk(0, 0, 0, 1, 1, 1, 32'hC, 32'hFE420AE3, 1, 32'h10, 0);
        tv[6]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tv[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
        tv[8]  = mk(0, 0, 0, 0, 1, 1, 32'h0, 32'hFFC4A303, 1, 32'h4, 0);
        for (int i = 9; i <= 12; i++) tv[i] = mk(0, 0, 0, 0, 1, 1, 32'h0, 32'hFFC4A303, 2, 32'h8, 0);
        tv[13] = mk(0, 0, 0, 1, 1, 1, 32'h0, 32'hFFC4A303, 2, 32'h8, 0);
        tv[14] = mk(0, 0, 0, 1, 1, 1, 32'h4, 32'h0064A423, 2, 32'hC, 0);
        tv[15] = mk(0, 0, 0, 1, 1, 1, 32'h8, 32'h0062E233, 2, 32'h10, 0);
        tv[16] = mk(0, 1, 32'h40, 1, 1, 0, 32'hC, 32'hFE420AE3, 2, 32'h14, 0);
        tv[17] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h40, 0);
        tv[18] = mk(0, 0, 0, 1, 1, 1, 32'h40, mem(32'h40), 1, 32'h44, 0);
        tv[19] = mk(0, 1, 32'h42, 1, 1, 0, 32'h44, mem(32'h44), 1, 32'h48, 0);
        tv[20] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h40, 1);
        tv[21] = mk(0, 0, 0, 1, 1, 1, 32'h40, mem(32'h40), 1, 32'h44, 0);
        tv[22] = mk(0, 1, 32'hFFFF_FFFC, 1, 1, 0, 32'h44, mem(32'h44), 1, 32'h48, 0);
        tv[23] = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
        tv[24] = mk(0, 0, 0, 1, 1, 1, 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1, 32'h0, 0);
        tv[25] = mk(0, 0, 0, 1, 1, 1, 32'h0, 32'hFFC4A303, 1, 32'h4, 0);
        tv[26] = mk(0, 0, 0, 1, 1, 1, 32'h4, 32'h0064A423, 1, 32'h8, 0);
        tv[27] = mk(0, 0, 0, 0, 1, 1, 32'h8, 32'h0062E233, 1, 32'hC, 0);
        tv[28] = mk(0, 0, 0, 0, 1, 1, 32'h8, 32'h0062E233, 2, 32'h10, 0);
        tv[29] = mk(1, 1, 32'h80, 0, 1, 0, 32'h8, 32'h0062E233, 2, 32'h10, 0);
        tv[30] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 31; i++) begin
            drive(tv[i].rst, tv[i].rv, tv[i].rpc, tv[i].rdy);
            if (tv[i].chk) check_all(tv[i].v, tv[i].pc, tv[i].instr, tv[i].lvl, tv[i].addr, tv[i].mis);
            finish_cycle();
        end
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? {28'hFFFF_FFF, 4'($urandom)} : $urandom;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 3) != 0);
            check_all(mq.size() > 0 && !redirect_valid,
                      mq.size() > 0 ? mq[0].pc : 32'h0,
                      mq.size() > 0 ? mq[0].instr : 32'h0,
                      mq.size(), mpc, mmis);
            finish_cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
